i2s_transmitter: RTL

//   I2S-style serial transmitter, the sending end of the link our receiver decodes.

---
 rtl/i2s_transmitter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/i2s_transmitter.sv
// I2S serial transmitter: buffers one left/right pair behind a valid/ready handshake
// and shifts it out MSB-first with wordSelect framing, changing outputs on posedge.
module i2s_transmitter #(
  parameter int unsigned DATA_SIZE = 32
) (
  input  logic                 sck_clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  input  logic [DATA_SIZE-1:0] leftSample,
  input  logic [DATA_SIZE-1:0] rightSample,
  output logic                 wordSelect,
  output logic                 data,
  output logic                 underrun
);

  localparam int unsigned CNT_W = (DATA_SIZE > 2) ? $clog2(DATA_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_n;
  logic [DATA_SIZE-1:0] hold_l, hold_l_n, hold_r, hold_r_n;
  logic                 hold_full, hold_full_n;
  logic [DATA_SIZE-1:0] shift_l, shift_l_n, shift_r, shift_r_n;
  logic [CNT_W-1:0]     bitcnt, bitcnt_n;
  logic                 slot, slot_n;            // 0 = left, 1 = right
  logic                 ws_n, data_n, underrun_n;
  logic                 frame_start, accept;

  assign sample_ready = !hold_full;

  // State and datapath registers
  always_ff @(posedge sck_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_l     <= '0;
      hold_r     <= '0;
      hold_full  <= 1'b0;
      shift_l    <= '0;
      shift_r    <= '0;
      bitcnt     <= '0;
      slot       <= 1'b0;
      wordSelect <= 1'b0;
      data       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      hold_l     <= hold_l_n;
      hold_r     <= hold_r_n;
      hold_full  <= hold_full_n;
      shift_l    <= shift_l_n;
      shift_r    <= shift_r_n;
      bitcnt     <= bitcnt_n;
      slot       <= slot_n;
      wordSelect <= ws_n;
      data       <= data_n;
      underrun   <= underrun_n;
    end
  end

  // Next-state, serialiser and buffer logic
  always_comb begin
    state_n     = state;
    hold_l_n    = hold_l;
    hold_r_n    = hold_r;
    hold_full_n = hold_full;
    shift_l_n   = shift_l;
    shift_r_n   = shift_r;
    bitcnt_n    = bitcnt;
    slot_n      = slot;
    ws_n        = wordSelect;
    data_n      = data;
    underrun_n  = 1'b0;
    frame_start = 1'b0;
    accept      = sample_valid && !hold_full;

    case (state)
      IDLE: begin
        ws_n   = 1'b0;
        data_n = 1'b0;
        if (enable) frame_start = 1'b1;
      end
      RUN: begin
        if (slot && bitcnt == LAST_BIT) begin
          if (enable) begin
            frame_start = 1'b1;
          end else begin
            state_n = IDLE;
            ws_n    = 1'b0;
            data_n  = 1'b0;
          end
        end else if (bitcnt == LAST_BIT) begin
          bitcnt_n = '0;
          slot_n   = 1'b1;
          ws_n     = 1'b1;
          data_n   = shift_r[DATA_SIZE-1];
        end else begin
          bitcnt_n = bitcnt + 1'b1;
          if (slot) begin
            data_n    = shift_r[DATA_SIZE-2];
            shift_r_n = shift_r << 1;
          end else begin
            data_n    = shift_l[DATA_SIZE-2];
            shift_l_n = shift_l << 1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Frame load always uses the pre-edge buffer; a same-edge accept waits for the next frame
    if (frame_start) begin
      state_n  = RUN;
      bitcnt_n = '0;
      slot_n   = 1'b0;
      ws_n     = 1'b0;
      if (hold_full) begin
        shift_l_n   = hold_l;
        shift_r_n   = hold_r;
        hold_full_n = 1'b0;
        data_n      = hold_l[DATA_SIZE-1];
      end else begin
        shift_l_n  = '0;
        shift_r_n  = '0;
        data_n     = 1'b0;
        underrun_n = 1'b1;
      end
    end

    if (accept) begin
      hold_l_n    = leftSample;
      hold_r_n    = rightSample;
      hold_full_n = 1'b1;
    end
  end

endmodule
